fetch_stage: RTL and testbench

Instruction fetch stage for the 5-stage RV32I pipeline: the producer end of the 32-bit instruction word the decoder consumes. Owns the PC and talks to instruction memory over a single-outstanding req/valid handshake. Drives the IF/ID pipeline register, meaning the instruction, its PC and a valid bit. Honours stall from hazard detection and redirect from branch/jump resolution.

---
 rtl/rv_pkg.sv | 16 +
 rtl/fetch_hold_buf.sv | 32 +++
 rtl/fetch_stage.sv | 171 +++++++++++++++++
 tb/tb_fetch_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: data width, canonical NOP, fetch FSM states.
package rv_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] RV_NOP           = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StHold,
    StFault
  } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer holding an instruction word and its PC while decode is stalled.
module fetch_hold_buf
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = rv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [31:0]     load_word,
  input  logic [XLEN-1:0] load_pc,
  output logic [31:0]     word,
  output logic [XLEN-1:0] pc,
  output logic            valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      word  <= RV_NOP;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= load_word;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, single-outstanding imem handshake, IF/ID register.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned XLEN     = rv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            id_valid,
  output logic            fetch_fault
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic            id_valid_q, id_valid_d;

  logic            hold_load, hold_clear, hold_valid;
  logic [31:0]     hold_word;
  logic [XLEN-1:0] hold_pc;

  logic            redirect_bad;
  logic [XLEN-1:0] redirect_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_bad = (redirect_pc[1:0] != 2'b00);
  assign redirect_tgt = redirect_pc;
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redirect_bad = 1'b0;
  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
`endif

  fetch_hold_buf #(
    .XLEN (XLEN)
  ) u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load),
    .clear     (hold_clear),
    .load_word (imem_rdata),
    .load_pc   (pc_q),
    .word      (hold_word),
    .pc        (hold_pc),
    .valid     (hold_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (imem_valid) state_d = stall ? StHold : StFetch;
      StDrain: if (imem_valid) state_d = StFetch;
      StHold:  if (!stall) state_d = StFetch;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
    // Redirect wins over everything; a request still in flight must be drained first.
    if (redirect) begin
      if (redirect_bad) begin
        state_d = StFault;
      end else if ((state_q == StFetch || state_q == StDrain) && !imem_valid) begin
        state_d = StDrain;
      end else begin
        state_d = StFetch;
      end
    end
  end

  always_comb begin
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    id_valid_d   = id_valid_q;
    hold_load    = 1'b0;
    hold_clear   = 1'b0;
    if (redirect) begin
      id_valid_d = 1'b0;
      hold_clear = 1'b1;
      if (!redirect_bad) pc_d = redirect_tgt;
      // Keep presenting the stale address until its response comes back.
      if (state_q == StFetch && !imem_valid) drain_addr_d = pc_q;
    end else begin
      if (!stall) id_valid_d = 1'b0;
      case (state_q)
        StFetch: begin
          if (imem_valid) begin
            pc_d = pc_q + XLEN'(4);
            if (stall) begin
              hold_load = 1'b1;
            end else begin
              id_instr_d = imem_rdata;
              id_pc_d    = pc_q;
              id_valid_d = 1'b1;
            end
          end
        end
        StHold: begin
          if (!stall) begin
            id_instr_d = hold_word;
            id_pc_d    = hold_pc;
            id_valid_d = hold_valid;
            hold_clear = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      id_instr_q   <= RV_NOP;
      id_pc_q      <= '0;
      id_valid_q   <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      id_valid_q   <= id_valid_d;
    end
  end

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    fetch_fault = 1'b0;
    case (state_q)
      StFetch: imem_req = 1'b1;
      StDrain: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      StFault: fetch_fault = 1'b1;
`endif
      default: ;
    endcase
  end

  assign id_instr = id_instr_q;
  assign id_pc    = id_pc_q;
  assign id_valid = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage against a flag-based behavioural model.
module tb_fetch_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_valid;
  logic        fetch_fault;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .XLEN     (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_valid    (id_valid),
    .fetch_fault (fetch_fault)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Model: what the fetch unit is doing, as plain facts.
  logic [31:0] m_pc, m_stale_addr, m_held_word, m_held_pc, m_id_instr, m_id_pc;
  logic        m_idle, m_stale, m_held, m_fault, m_id_valid;

  // Random-phase memory.
  logic        mem_busy = 1'b0;
  int unsigned mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_stale_addr = 32'h0; m_held_word = 32'h0; m_held_pc = 32'h0;
    m_id_instr = RV_NOP; m_id_pc = 32'h0; m_id_valid = 1'b0;
    m_idle = 1'b1; m_stale = 1'b0; m_held = 1'b0; m_fault = 1'b0;
  endtask

  task automatic model_step();
    logic req_now;
    req_now = !m_idle && !m_held && !m_fault;
    if (rst) begin
      model_reset();
      return;
    end
    if (redirect) begin
      m_id_valid = 1'b0;
      m_held     = 1'b0;
      m_idle     = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        m_fault = 1'b1;
        m_stale = 1'b0;
        return;
      end
`endif
      m_fault = 1'b0;
      if (req_now && !imem_valid) begin
        if (!m_stale) m_stale_addr = m_pc;
        m_stale = 1'b1;
      end else begin
        m_stale = 1'b0;
      end
      m_pc = redirect_pc & ~32'h3;
      return;
    end
    if (m_idle) begin
      m_idle = 1'b0;
      if (!stall) m_id_valid = 1'b0;
    end else if (m_fault) begin
      m_id_valid = 1'b0;
    end else if (m_held) begin
      if (!stall) begin
        m_id_instr = m_held_word; m_id_pc = m_held_pc; m_id_valid = 1'b1; m_held = 1'b0;
      end
    end else if (m_stale) begin
      if (imem_valid) m_stale = 1'b0;
      if (!stall) m_id_valid = 1'b0;
    end else if (imem_valid && stall) begin
      m_held = 1'b1; m_held_word = imem_rdata; m_held_pc = m_pc; m_pc = m_pc + 32'd4;
    end else if (imem_valid) begin
      m_id_instr = imem_rdata; m_id_pc = m_pc; m_id_valid = 1'b1; m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      m_id_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    logic exp_req;
    exp_req = !m_idle && !m_held && !m_fault;
    chk({tag, ".req"}, 32'(imem_req), 32'(exp_req));
    if (exp_req || m_idle) chk({tag, ".addr"}, imem_addr, m_stale ? m_stale_addr : m_pc);
    chk({tag, ".id_valid"}, 32'(id_valid), 32'(m_id_valid));
    chk({tag, ".id_instr"}, id_instr, m_id_instr);
    chk({tag, ".id_pc"}, id_pc, m_id_pc);
    chk({tag, ".fault"}, 32'(fetch_fault), 32'(m_fault));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_valid = 1'b0; imem_rdata = '0;
    tick("reset");
    chk("reset.nop", id_instr, 32'h0000_0013);
    chk("reset.addr0", imem_addr, 32'h0);
    rst = 1'b0;
    tick("fetch0");
    chk("fetch0.req_up", 32'(imem_req), 32'd1);

    imem_valid = 1'b1; imem_rdata = 32'h0050_0093;
    tick("acc0");
    chk("acc0.instr", id_instr, 32'h0050_0093);
    chk("acc0.next_addr", imem_addr, 32'h4);
    imem_valid = 1'b0;
    tick("bubble");

    imem_valid = 1'b1; imem_rdata = 32'h0020_8133; stall = 1'b1;
    tick("hold");
    chk("hold.req_low", 32'(imem_req), 32'd0);
    chk("hold.id_kept", id_instr, 32'h0050_0093);
    imem_valid = 1'b0;
    tick("hold2");
    stall = 1'b0;
    tick("release");
    chk("release.instr", id_instr, 32'h0020_8133);
    chk("release.addr", imem_addr, 32'h8);
    tick("req8");

    redirect = 1'b1; redirect_pc = 32'h100;
    tick("drain");
    chk("drain.old_addr", imem_addr, 32'h8);
    redirect = 1'b0; imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick("drop");
    chk("drop.not_taken", id_instr, 32'h0020_8133);
    chk("drop.new_addr", imem_addr, 32'h100);
    imem_valid = 1'b0;
    tick("t100");

    redirect = 1'b1; redirect_pc = 32'h200; imem_valid = 1'b1; stall = 1'b1;
    imem_rdata = 32'h0BAD_F00D;
    tick("redir_same");
    chk("redir_same.vld", 32'(id_valid), 32'd0);
    chk("redir_same.addr", imem_addr, 32'h200);
    redirect = 1'b0; imem_valid = 1'b0; stall = 1'b0;
    tick("idle200");

    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_valid = 1'b1;
    tick("to_top");
    redirect = 1'b0; imem_valid = 1'b0;
    tick("top_wait");
    imem_valid = 1'b1; imem_rdata = 32'h0000_006F;
    tick("wrap");
    chk("wrap.pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap.addr", imem_addr, 32'h0);
    imem_valid = 1'b0;
    tick("wrap_wait");

    redirect = 1'b1; redirect_pc = 32'h102; imem_valid = 1'b1; imem_rdata = 32'h1111_1111;
    tick("misalign");
`ifdef FETCH_ALIGN_CHECK_EN
    chk("misalign.fault", 32'(fetch_fault), 32'd1);
    redirect = 1'b0; imem_valid = 1'b0;
    tick("fault1");
    tick("fault2");
    chk("fault2.req_low", 32'(imem_req), 32'd0);
    chk("fault2.sticky", 32'(fetch_fault), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick("unfault");
    chk("unfault.fault", 32'(fetch_fault), 32'd0);
    chk("unfault.addr", imem_addr, 32'h200);
`else
    chk("misalign.fault", 32'(fetch_fault), 32'd0);
    chk("misalign.addr", imem_addr, 32'h100);
`endif
    redirect = 1'b0; imem_valid = 1'b0;
    tick("settle");

    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      stall       = ($urandom_range(0, 2) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom;
      if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
      imem_valid  = 1'b0;
      imem_rdata  = $urandom;
      if (rst || !imem_req) begin
        mem_busy = 1'b0;
      end else if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = $urandom_range(1, 3);
        mem_addr = imem_addr;
      end else begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem_word(mem_addr);
          mem_busy   = 1'b0;
        end
      end
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
